// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Issue/read/writeback bundle between the pipeline (master) and the register file (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic                      stall;
  logic                      flush;
  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0][XLEN-1:0]  rd_data;
  logic [NRD-1:0]            rd_busy;
  logic [NWR-1:0]            wr_en;
  logic [NWR-1:0][AW-1:0]    wr_addr;
  logic [NWR-1:0][XLEN-1:0]  wr_data;
  logic                      issue_en;
  logic [AW-1:0]             issue_addr;

  modport master (
    output stall, flush, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  stall, flush, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy vector: set on issue, cleared on writeback or flush, frozen by stall.
// Writeback masking of rd_busy is enabled by REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  input  logic [NWR-1:0]         wr_qual,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  output logic [NRD-1:0]         rd_busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Order matters: clear, then set (new producer wins), then flush overrides all.
  always_comb begin
    busy_next = busy_reg;
    if (!stall) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p]) busy_next[wr_addr[p]] = 1'b0;
      end
      if (issue_en && issue_addr != '0) busy_next[issue_addr] = 1'b1;
      if (flush) busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_busy[j] = busy_reg[rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p] && wr_addr[p] == rd_addr[j]) rd_busy[j] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-first bypass on rd_data and writeback masking on rd_busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]           regs_reg [NREGS];
  logic [NWR-1:0]            wr_qual;
  logic [NRD-1:0][XLEN-1:0]  rd_val;

  genvar gi;

  generate
    for (gi = 0; gi < NWR; gi++) begin : g_qual
      assign wr_qual[gi] = bus.wr_en[gi] && !bus.stall && (bus.wr_addr[gi] != '0);
    end
  endgenerate

  // Higher port index is visited last, so its non-blocking assignment wins a collision.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) begin
          regs_reg[gi] <= '0;
        end
      end else begin : g_store
        always_ff @(posedge clk) begin
          if (reset) begin
            regs_reg[gi] <= '0;
          end else begin
            for (int p = 0; p < NWR; p++) begin
              if (wr_qual[p] && bus.wr_addr[p] == AW'(gi)) regs_reg[gi] <= bus.wr_data[p];
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_val[j] = regs_reg[bus.rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p] && bus.wr_addr[p] == bus.rd_addr[j]) rd_val[j] = bus.wr_data[p];
      end
`endif
      if (bus.rd_addr[j] == '0) rd_val[j] = '0;
    end
  end

  assign bus.rd_data = rd_val;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .stall      (bus.stall),
    .flush      (bus.flush),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .wr_qual    (wr_qual),
    .wr_addr    (bus.wr_addr),
    .rd_addr    (bus.rd_addr),
    .rd_busy    (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (NRD=2, NWR=2); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic        port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  exp_t  exp_q[$];
  string name_q[$];

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] r0, input logic [4:0] r1);
    bus.stall      = st;
    bus.flush      = fl;
    bus.wr_en      = we;
    bus.wr_addr[0] = wa0;
    bus.wr_data[0] = wd0;
    bus.wr_addr[1] = wa1;
    bus.wr_data[1] = wd1;
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    bus.rd_addr[0] = r0;
    bus.rd_addr[1] = r1;
  endtask

  task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic push(input int port, input logic [31:0] d, input logic b, input string nm);
    exp_t e;
    e.cyc  = cycle;
    e.port = port[0];
    e.data = d;
    e.busy = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: each cycle, retire every expectation tagged with that cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cycle) begin
      exp_t  e;
      string nm;
      logic [31:0] ad;
      logic        ab;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      ad = bus.rd_data[e.port];
      ab = bus.rd_busy[e.port];
      n_vec++;
      if (int'(e.cyc) != cycle || ad !== e.data || ab !== e.busy) begin
        n_bad++;
        $display("FAIL %s: cyc %0d/%0d port %0d data=%h busy=%b, expected data=%h busy=%b",
                 nm, cycle, e.cyc, e.port, ad, ab, e.data, e.busy);
      end else begin
        $display("ok   %s: port %0d data=%h busy=%b", nm, e.port, ad, ab);
      end
    end
  end

  initial begin
    rd(0, 0);
    step();
    reset = 1'b0;
    rd(5, 31);
    push(0, 32'h0, 0, "rst_x5");
    push(1, 32'h0, 0, "rst_x31");

    step(); drive(0, 0, 2'b01, 3, 32'hDEADBEEF, 0, 0, 0, 0, 3, 3);
    push(0, BYP ? 32'hDEADBEEF : 32'h0, 0, "wr_x3_same_p0");
    push(1, BYP ? 32'hDEADBEEF : 32'h0, 0, "wr_x3_same_p1");
    step(); rd(3, 0);
    push(0, 32'hDEADBEEF, 0, "wr_x3_next");
    push(1, 32'h0, 0, "x0_idle");

    step(); drive(0, 0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0);
    push(0, 32'h0, 0, "x0_wr_same");
    step(); rd(0, 0);
    push(0, 32'h0, 0, "x0_wr_next");
    push(1, 32'h0, 0, "x0_issue_busy");

    step(); drive(0, 0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7);
    push(0, BYP ? 32'h22 : 32'h0, 0, "coll_same");
    step(); rd(7, 7);
    push(0, 32'h22, 0, "coll_next");

    step(); drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0);
    push(0, 32'h0, 0, "iss_x9_same");
    step(); rd(9, 0);
    push(0, 32'h0, 1, "iss_x9_next");
    for (int k = 0; k < 3; k++) begin
      step(); drive(1, 0, 2'b01, 9, 32'hAA, 0, 0, 0, 0, 9, 0);
      push(0, 32'h0, 1, "stall_wr_x9");
    end
    step(); rd(9, 0);
    push(0, 32'h0, 1, "post_stall_x9");
    step(); drive(0, 0, 2'b01, 9, 32'h5, 0, 0, 0, 0, 9, 0);
    push(0, BYP ? 32'h5 : 32'h0, BYP ? 1'b0 : 1'b1, "wb_x9_same");
    step(); rd(9, 0);
    push(0, 32'h5, 0, "wb_x9_next");

    step(); drive(0, 0, 2'b10, 0, 0, 4, 32'h44, 1, 4, 0, 4);
    push(1, BYP ? 32'h44 : 32'h0, 0, "setwin_same");
    step(); rd(0, 4);
    push(1, 32'h44, 1, "setwin_next");
    step(); drive(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4);
    push(1, 32'h44, 1, "flush_same");
    step(); rd(0, 4);
    push(1, 32'h44, 0, "flush_clr");

    step(); drive(0, 1, 2'b00, 0, 0, 0, 0, 1, 10, 0, 0);
    step(); rd(10, 0);
    push(0, 32'h0, 0, "flush_over_iss");

    step(); drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 11, 0, 0);
    step(); drive(1, 1, 2'b00, 0, 0, 0, 0, 1, 13, 11, 0);
    push(0, 32'h0, 1, "stall_flush_same");
    step(); rd(11, 13);
    push(0, 32'h0, 1, "stall_blocks_flush");
    push(1, 32'h0, 0, "stall_blocks_iss");

    step(); reset = 1'b1; drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 11);
    step(); reset = 1'b0; rd(3, 11);
    push(0, 32'h0, 0, "rst_mid_x3");
    push(1, 32'h0, 0, "rst_mid_b11");
    step(); drive(0, 0, 2'b01, 11, 32'h77, 0, 0, 0, 0, 0, 11);
    push(1, BYP ? 32'h77 : 32'h0, 0, "post_rst_wb_same");
    step(); rd(0, 11);
    push(1, 32'h77, 0, "post_rst_wb_next");

    step(); rd(0, 0);
    step();
    step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: run not complete at time %0t, expected completion", $time);
      $fatal(1, "watchdog");
    end
  end

endmodule
